// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM port between an instruction fetch port and a data port.
// Data wins by default; a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
`timescale 1ns/1ps
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    input  logic        ram_error
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DACC = 2'd1, IACC = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic          wr_q, wr_d;

    logic data_pending;
    logic starved;
    logic done;
    logic d_done;
    logic i_done;

    assign data_pending = dREN | dWEN;
    assign starved      = iREN && (cnt_q == CW'(STARVE_LIMIT));
    // An errored ready is a retry, not a completion.
    assign done         = ram_ready && !ram_error;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (iREN && (starved || !data_pending)) begin
                    state_d = IACC;
                    cnt_d   = '0;
                    addr_d  = iaddr;
                    store_d = '0;
                    wr_d    = 1'b0;
                end else if (data_pending) begin
                    // Below the limit whenever iREN is high here, so the increment cannot wrap.
                    state_d = DACC;
                    cnt_d   = iREN ? cnt_q + CW'(1) : '0;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else begin
                    cnt_d = '0;
                end
            end
            DACC, IACC: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = (state_q != IDLE) && !wr_q;
        ramWEN   = (state_q != IDLE) && wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        // A requester that dropped its request mid-access gets no completion.
        d_done   = (state_q == DACC) && done && data_pending;
        i_done   = (state_q == IACC) && done && iREN;
        dwait    = data_pending && !d_done;
        iwait    = iREN && !i_done;
        dload    = (d_done && !wr_q) ? ramload : 32'd0;
        iload    = i_done ? ramload : 32'd0;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: inputs change just after the falling edge,
// outputs are checked 1 ns later, well clear of the rising edge.
`timescale 1ns/1ps
module tb_memory_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        ram_error;

    int errors = 0;
    int checks = 0;

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .ram_error(ram_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ram_ready = 0; ram_error = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        clear_inputs();
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN got=%0b want=0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_ramWEN got=%0b want=0", ramWEN); end
        checks++; if (ramaddr !== 32'd0) begin errors++; $display("FAIL rst_ramaddr got=%h want=0", ramaddr); end
        checks++; if (ramstore !== 32'd0) begin errors++; $display("FAIL rst_ramstore got=%h want=0", ramstore); end
        checks++; if (dwait !== 1'b0 || iwait !== 1'b0) begin errors++; $display("FAIL rst_wait got=%0b%0b want=00", dwait, iwait); end
        @(negedge CLK); @(negedge CLK);
        RST = 0;
        $display("txn reset released");
    endtask

    task automatic test_priority();
        @(negedge CLK);
        dREN = 1; daddr = 32'h0000_0010; iREN = 1; iaddr = 32'h0000_0020;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL prio_idle_ren got=%0b want=0", ramREN); end
        checks++; if (dwait !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL prio_idle_wait got=%0b%0b want=11", dwait, iwait); end
        @(negedge CLK);
        ram_ready = 1; ramload = 32'hA5A5_0001;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin errors++; $display("FAIL prio_dgrant got=%0b/%h want=1/00000010", ramREN, ramaddr); end
        checks++; if (dwait !== 1'b0 || dload !== 32'hA5A5_0001) begin errors++; $display("FAIL prio_ddone got=%0b/%h want=0/a5a50001", dwait, dload); end
        checks++; if (iwait !== 1'b1 || iload !== 32'd0) begin errors++; $display("FAIL prio_istall got=%0b/%h want=1/0", iwait, iload); end
        $display("txn data read addr=%h data=%h", ramaddr, dload);
        @(negedge CLK);
        ram_ready = 0; dREN = 0;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL prio_gap got=%0b want=0", ramREN); end
        @(negedge CLK);
        ram_ready = 1; ramload = 32'hA5A5_0002;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h20) begin errors++; $display("FAIL prio_igrant got=%0b/%h want=1/00000020", ramREN, ramaddr); end
        checks++; if (iwait !== 1'b0 || iload !== 32'hA5A5_0002) begin errors++; $display("FAIL prio_idone got=%0b/%h want=0/a5a50002", iwait, iload); end
        $display("txn inst fetch addr=%h data=%h", ramaddr, iload);
        @(negedge CLK);
        clear_inputs();
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL prio_end got=%0b want=0", ramREN); end
    endtask

    task automatic test_write_latency();
        @(negedge CLK);
        dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            if (c == 1) begin daddr = 32'h999; dstore = 32'h0; end
            ram_ready = (c == 3); ramload = 32'h55;
            #1;
            checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL wr_strobe c=%0d got=%0b%0b want=10", c, ramWEN, ramREN); end
            checks++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_latch c=%0d got=%h/%h want=00000100/deadbeef", c, ramaddr, ramstore); end
            checks++; if (dwait !== (c != 3)) begin errors++; $display("FAIL wr_dwait c=%0d got=%0b want=%0b", c, dwait, (c != 3)); end
        end
        checks++; if (dload !== 32'd0) begin errors++; $display("FAIL wr_dload got=%h want=0", dload); end
        $display("txn data write addr=%h data=%h", ramaddr, ramstore);
        @(negedge CLK);
        clear_inputs();
        #1;
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL wr_drop got=%0b want=0", ramWEN); end
    endtask

    task automatic test_error_retry();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h40;
        @(negedge CLK);
        ram_ready = 1; ram_error = 1; ramload = 32'hBAD0_BAD0;
        #1;
        checks++; if (iwait !== 1'b1 || iload !== 32'd0) begin errors++; $display("FAIL err_stall got=%0b/%h want=1/0", iwait, iload); end
        @(negedge CLK);
        ram_error = 0; ramload = 32'h1234_5678;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL err_reissue got=%0b/%h want=1/00000040", ramREN, ramaddr); end
        checks++; if (iwait !== 1'b0 || iload !== 32'h1234_5678) begin errors++; $display("FAIL err_done got=%0b/%h want=0/12345678", iwait, iload); end
        $display("txn inst fetch retry addr=%h data=%h", ramaddr, iload);
        @(negedge CLK);
        clear_inputs();
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL err_end got=%0b want=0", ramREN); end
    endtask

    task automatic test_drop_and_idle_ready();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h60;
        @(negedge CLK);
        iREN = 0;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h60) begin errors++; $display("FAIL drop_busy got=%0b/%h want=1/00000060", ramREN, ramaddr); end
        checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL drop_iwait got=%0b want=0", iwait); end
        @(negedge CLK);
        ram_ready = 1; ramload = 32'hCAFE_0001;
        #1;
        checks++; if (iwait !== 1'b0 || iload !== 32'd0) begin errors++; $display("FAIL drop_discard got=%0b/%h want=0/0", iwait, iload); end
        @(negedge CLK);
        ram_ready = 0;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_idle got=%0b want=0", ramREN); end
        $display("txn inst fetch dropped addr=%h", ramaddr);
        @(negedge CLK);
        ram_ready = 1; ramload = 32'h1111_1111;
        #1;
        checks++; if (dload !== 32'd0 || iload !== 32'd0) begin errors++; $display("FAIL idle_ready_load got=%h/%h want=0/0", dload, iload); end
        @(negedge CLK);
        ram_ready = 0;
        #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL idle_ready_state got=%0b%0b want=00", ramREN, ramWEN); end
        $display("txn idle ready ignored");
    endtask

    task automatic test_starvation();
        @(negedge CLK);
        dREN = 1; iREN = 1; daddr = 32'h200; iaddr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            ram_ready = 1; ramload = 32'h0B00 + k;
            #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 + 4 * k) begin errors++; $display("FAIL starve_d%0d_addr got=%0b/%h want=1/%h", k, ramREN, ramaddr, 32'h200 + 4 * k); end
            checks++; if (dut.cnt_q !== 3'(k + 1)) begin errors++; $display("FAIL starve_d%0d_cnt got=%0d want=%0d", k, dut.cnt_q, k + 1); end
            checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL starve_d%0d_wait got=%0b%0b want=01", k, dwait, iwait); end
            $display("txn data read addr=%h data=%h", ramaddr, dload);
            @(negedge CLK);
            ram_ready = 0; daddr = 32'h200 + 4 * (k + 1);
            #1;
            checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL starve_d%0d_gap got=%0b want=0", k, ramREN); end
        end
        @(negedge CLK);
        ram_ready = 1; ramload = 32'h0C0C_0C0C;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin errors++; $display("FAIL starve_igrant got=%0b/%h want=1/00000080", ramREN, ramaddr); end
        checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL starve_cnt_clr got=%0d want=0", dut.cnt_q); end
        checks++; if (iwait !== 1'b0 || iload !== 32'h0C0C_0C0C || dwait !== 1'b1) begin errors++; $display("FAIL starve_idone got=%0b/%h/%0b want=0/0c0c0c0c/1", iwait, iload, dwait); end
        $display("txn inst fetch after starvation addr=%h data=%h", ramaddr, iload);
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        dREN = 1; iREN = 1; daddr = 32'h300;
        @(negedge CLK);
        #1;
        checks++; if (ramREN !== 1'b1 || dut.cnt_q !== 3'd1) begin errors++; $display("FAIL rstmid_pre got=%0b/%0d want=1/1", ramREN, dut.cnt_q); end
        #2;
        RST = 1;
        #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rstmid_strobe got=%0b%0b want=00", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'd0 || dut.cnt_q !== 3'd0) begin errors++; $display("FAIL rstmid_state got=%h/%0d want=0/0", ramaddr, dut.cnt_q); end
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);
        ram_ready = 1; ramload = 32'h7777_0000;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL rstmid_regrant got=%0b/%h want=1/00000300", ramREN, ramaddr); end
        checks++; if (dwait !== 1'b0 || dload !== 32'h7777_0000) begin errors++; $display("FAIL rstmid_done got=%0b/%h want=0/77770000", dwait, dload); end
        $display("txn data read after reset addr=%h data=%h", ramaddr, dload);
        @(negedge CLK);
        clear_inputs();
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rstmid_end got=%0b want=0", ramREN); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_write_latency();
        test_error_retry();
        test_drop_and_idle_ready();
        test_starvation();
        test_reset_mid();
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
